// File: rtl/bin2ascii_converter_if.sv
// Start/done handshake and result bundle for bin2ascii_converter.
interface bin2ascii_converter_if #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [BIN_W-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   ascii;

  modport master (
    output start, value,
    input  busy, done, overflow, ascii
  );

  modport slave (
    input  start, value,
    output busy, done, overflow, ascii
  );
endinterface

// File: rtl/bin2ascii_converter.sv
// Iterative double-dabble binary to decimal-ASCII converter
// with leading-zero blanking and overflow saturation.
module bin2ascii_converter #(
  parameter int         BIN_W      = 7,
  parameter int         DIGITS     = 2,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [6:0] BLANK_CHAR = 7'h20,
  parameter logic [6:0] OVF_CHAR   = 7'h2D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bin2ascii_converter_if.slave bus
);

  function automatic int calc_nb(input int w);
    longint m;
    int     n;
    m = (longint'(1) << w) - 1;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (m >= 10) begin
        m = m / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int NB = calc_nb(BIN_W);
  localparam int NW = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FMT
  } state_t;

  state_t                state, state_n;
  logic [BIN_W-1:0]      shift, shift_n;
  logic [4*NB-1:0]       bcd, bcd_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  busy, busy_n;
  logic                  done, done_n;
  logic                  ovf, ovf_n;
  logic [7*DIGITS-1:0]   ascii, ascii_n;

  logic [4*NB-1:0]       adj;
  logic [4*NW-1:0]       ext;
  logic                  fmt_ovf;
  logic                  lead;
  logic [7*DIGITS-1:0]   fmt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      ascii <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      ovf   <= ovf_n;
      ascii <= ascii_n;
    end
  end

  always_comb begin
    adj = bcd;
    for (int k = 0; k < NB; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Digits above DIGITS only exist to detect overflow.
  always_comb begin
    ext = '0;
    ext[4*NB-1:0] = bcd;
    fmt_ovf = 1'b0;
    for (int k = DIGITS; k < NW; k++) begin
      if (ext[4*k +: 4] != 4'd0)
        fmt_ovf = 1'b1;
    end
    fmt  = '0;
    lead = BLANK_LZ;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (fmt_ovf) begin
        fmt[7*k +: 7] = OVF_CHAR;
      end else if (lead && k != 0 &&
                   ext[4*k +: 4] == 4'd0) begin
        fmt[7*k +: 7] = BLANK_CHAR;
      end else begin
        fmt[7*k +: 7] = 7'h30 + {3'b000, ext[4*k +: 4]};
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    bcd_n   = bcd;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    ovf_n   = ovf;
    ascii_n = ascii;
    unique case (state)
      IDLE: begin
        // The done cycle itself does not accept a new request.
        if (bus.start && !done) begin
          shift_n = bus.value;
          bcd_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        {bcd_n, shift_n} = {adj, shift} << 1;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(BIN_W - 1))
          state_n = FMT;
      end
      FMT: begin
        ascii_n = fmt;
        ovf_n   = fmt_ovf;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = ovf;
  assign bus.ascii    = ascii;

endmodule

// File: tb/tb_bin2ascii_converter.sv
// Directed bench for bin2ascii_converter in three configurations,
// with a per-instance scoreboard checked on every done pulse.
module tb_bin2ascii_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin2ascii_converter_if #(.BIN_W(7),  .DIGITS(2)) if0 ();
  bin2ascii_converter_if #(.BIN_W(7),  .DIGITS(2)) if1 ();
  bin2ascii_converter_if #(.BIN_W(10), .DIGITS(4)) if2 ();

  bin2ascii_converter #(.BIN_W(7), .DIGITS(2), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  bin2ascii_converter #(.BIN_W(7), .DIGITS(2), .BLANK_LZ(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  bin2ascii_converter #(.BIN_W(10), .DIGITS(4), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  logic [14:0] q0[$];
  logic [14:0] q1[$];
  logic [28:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int i);
    case (i)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  task automatic drive(input int i, input logic s, input int v);
    case (i)
      0: begin if0.start = s; if0.value = v[6:0]; end
      1: begin if1.start = s; if1.value = v[6:0]; end
      default: begin if2.start = s; if2.value = v[9:0]; end
    endcase
  endtask

  task automatic push(input int i, input logic [28:0] e);
    case (i)
      0:       q0.push_back(e[14:0]);
      1:       q1.push_back(e[14:0]);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at a negedge; starts a conversion and checks latency.
  task automatic conv(input int i, input int v, input logic [28:0] e,
                      input int lat);
    bit seen;
    seen = 1'b0;
    push(i, e);
    drive(i, 1'b1, v);
    @(posedge clk);
    @(negedge clk);
    drive(i, 1'b0, 0);
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (get_done(i)) begin
        seen = 1'b1;
        chk($sformatf("latency_i%0d_v%0d", i, v), n, lat);
        chk($sformatf("busy_in_done_i%0d", i), get_busy(i), 0);
      end else if (n < lat) begin
        chk($sformatf("busy_i%0d_n%0d", i, n), get_busy(i), 1);
      end
    end
    if (!seen)
      chk($sformatf("timeout_i%0d_v%0d", i, v), 0, 1);
  endtask

  always @(negedge clk) begin
    if (if0.done) begin
      chk("sb_pending0", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        logic [14:0] e;
        e = q0.pop_front();
        chk("ascii0", if0.ascii, e[13:0]);
        chk("ovf0", if0.overflow, e[14]);
      end
    end
    if (if1.done) begin
      chk("sb_pending1", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        logic [14:0] e;
        e = q1.pop_front();
        chk("ascii1", if1.ascii, e[13:0]);
        chk("ovf1", if1.overflow, e[14]);
      end
    end
    if (if2.done) begin
      chk("sb_pending2", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        logic [28:0] e;
        e = q2.pop_front();
        chk("ascii2", if2.ascii, e[27:0]);
        chk("ovf2", if2.overflow, e[28]);
      end
    end
  end

  initial begin
    int n;
    bit seen;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ascii0", if0.ascii, 0);
    chk("rst_busy0", if0.busy, 0);
    chk("rst_done0", if0.done, 0);
    chk("rst_ovf0", if0.overflow, 0);
    chk("rst_ascii2", if2.ascii, 0);
    chk("rst_busy2", if2.busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ascii0", if0.ascii, 0);
    chk("idle_busy0", if0.busy, 0);
    chk("idle_ovf0", if0.overflow, 0);
    chk("idle_busy1", if1.busy, 0);

    conv(0, 47, {1'b0, 7'h34, 7'h37}, 8);
    @(negedge clk);
    conv(0, 5,  {1'b0, 7'h20, 7'h35}, 8);
    @(negedge clk);
    conv(0, 0,  {1'b0, 7'h20, 7'h30}, 8);
    @(negedge clk);
    conv(1, 5,  {1'b0, 7'h30, 7'h35}, 8);
    @(negedge clk);
    conv(0, 100, {1'b1, 7'h2D, 7'h2D}, 8);
    @(negedge clk);
    conv(0, 127, {1'b1, 7'h2D, 7'h2D}, 8);
    repeat (4) @(negedge clk);
    chk("hold_ascii0", if0.ascii, {7'h2D, 7'h2D});
    chk("hold_ovf0", if0.overflow, 1);
    conv(0, 99, {1'b0, 7'h39, 7'h39}, 8);
    @(negedge clk);

    push(0, {1'b0, 7'h31, 7'h32});
    drive(0, 1'b1, 12);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 12);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 88);
    @(negedge clk);
    drive(0, 1'b0, 88);
    n = 3;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (if0.done) seen = 1'b1;
    end
    chk("ignored_start_latency", n, 8);
    @(negedge clk);
    conv(0, 88, {1'b0, 7'h38, 7'h38}, 8);
    repeat (12) @(negedge clk);
    chk("no_second_done_q0", q0.size(), 0);

    drive(0, 1'b1, 55);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ascii0", if0.ascii, 0);
    chk("midrst_busy0", if0.busy, 0);
    chk("midrst_done0", if0.done, 0);
    chk("midrst_ovf0", if0.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_idle_busy0", if0.busy, 0);
    chk("midrst_idle_ascii0", if0.ascii, 0);

    conv(2, 1023, {1'b0, 7'h31, 7'h30, 7'h32, 7'h33}, 11);
    @(negedge clk);
    conv(2, 7, {1'b0, 7'h20, 7'h20, 7'h20, 7'h37}, 11);
    @(negedge clk);
    conv(2, 40, {1'b0, 7'h20, 7'h20, 7'h34, 7'h30}, 11);
    repeat (5) @(negedge clk);
    chk("sb_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
